// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared definitions for the sprite compositor. Holds the
//                per-sprite register offsets, CTRL bit positions, the video
//                timing constants, the sprite register record and the
//                built-in sprite image function.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package sprite_pkg;

  // Word offsets inside one sprite's 4-word register block
  localparam logic [1:0] REG_X    = 2'd0;
  localparam logic [1:0] REG_Y    = 2'd1;
  localparam logic [1:0] REG_IMG  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_HFLIP = 1;
  localparam int CTRL_VFLIP = 2;

  // Visible raster and the line on which shadow registers are committed
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int COMMIT_LINE = 480;

  // img is held at 4 bits so up to 16 images per ROM fit; only the low
  // $clog2(IMG_COUNT) bits are ever written.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] img;
    logic       en;
    logic       hflip;
    logic       vflip;
  } sprite_regs_t;

  // Built-in image set: a diagonal colour ramp per image. Every 16th
  // diagonal evaluates to palette index 0, giving transparent stripes.
  function automatic logic [3:0] sprite_pixel(input int img, input int row, input int col);
    return 4'(col + 2 * row + 3 * img + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_compositor_if
//  Description : Avalon-MM slave bus bundle for the sprite compositor.
//  Ports       : chipselect, write, read, address[ADDR_BITS], writedata[16]
//                driven by the master; readdata[16] driven by the slave.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
interface sprite_compositor_if #(
  parameter int ADDR_BITS = 6
);
  logic                 chipselect;
  logic                 write;
  logic                 read;
  logic [ADDR_BITS-1:0] address;
  logic [15:0]          writedata;
  logic [15:0]          readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/sprite_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom
//  Description : Single-port synchronous sprite image ROM,
//                depth IMG_COUNT*SPRITE_SIZE*SPRITE_SIZE, width COLOR_BITS.
//                Contents are the built-in image set realised as logic; an
//                empty ROM_FILE name yields an all-transparent ROM.
//  Ports       : clk     - system clock
//                addr_i  - {img, row, col} word address
//                q_o     - registered colour index (1 clk after addr_i)
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int SPRITE_SIZE = 32,
  parameter int IMG_COUNT   = 4,
  parameter int COLOR_BITS  = 4,
  parameter     ROM_FILE    = "sprites.mif",
  localparam int SZ_BITS    = $clog2(SPRITE_SIZE),
  localparam int IMG_BITS   = $clog2(IMG_COUNT),
  localparam int AW         = IMG_BITS + 2 * SZ_BITS
) (
  input  wire                   clk,
  input  wire  [AW-1:0]         addr_i,
  output logic [COLOR_BITS-1:0] q_o
);

  localparam bit HAS_IMAGE = |ROM_FILE;

  logic [IMG_BITS-1:0] img;
  logic [SZ_BITS-1:0]  row;
  logic [SZ_BITS-1:0]  col;

  assign img = addr_i[AW-1 -: IMG_BITS];
  assign row = addr_i[2*SZ_BITS-1 -: SZ_BITS];
  assign col = addr_i[SZ_BITS-1:0];

  always_ff @(posedge clk) begin
    q_o <= HAS_IMAGE ? COLOR_BITS'(sprite_pixel(int'(img), int'(row), int'(col))) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_compositor
//  Description : N hardware sprites with double-buffered registers, one ROM
//                per sprite, per-sprite flips, fixed priority (sprite 0 on
//                top) and sticky collision flags against sprite 0.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                bus                - Avalon-MM slave (register map access)
//                hcount, vcount     - raster position (column = hcount[10:1])
//                pix_valid/color/sprite - registered winning pixel, 2 clk
//                                     after the raster sample
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 32,
  parameter int IMG_COUNT   = 4,
  parameter int COLOR_BITS  = 4,
  parameter int ADDR_BITS   = 6,
  parameter     ROM_FILE    = "sprites.mif"
) (
  input  wire                   clk,
  input  wire                   reset,
  sprite_compositor_if.slave    bus,
  input  wire  [10:0]           hcount,
  input  wire  [9:0]            vcount,
  output logic                  pix_valid,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic [3:0]            pix_sprite
);

  localparam int SZ_BITS  = $clog2(SPRITE_SIZE);
  localparam int IMG_BITS = $clog2(IMG_COUNT);
  localparam int ROM_AW   = IMG_BITS + 2 * SZ_BITS;
  localparam logic [ADDR_BITS-1:0] A_STATUS = ADDR_BITS'(4 * NUM_SPRITES);
  localparam logic [ADDR_BITS-1:0] A_FRAME  = ADDR_BITS'(4 * NUM_SPRITES + 1);

  sprite_regs_t            shadow_q [NUM_SPRITES];
  sprite_regs_t            active_q [NUM_SPRITES];
  logic [15:0]             frame_q;
  logic [15:0]             readdata_q, readdata_d;
  logic [NUM_SPRITES-1:0]  collision_q, collision_d, coll_set;
  logic [NUM_SPRITES-1:0]  hit_s0, hit_s1_q, opaque;
  logic [COLOR_BITS-1:0]   rom_q [NUM_SPRITES];
  logic                    win_valid;
  logic [COLOR_BITS-1:0]   win_color;
  logic [3:0]              win_idx;
  logic                    rd_en, wr_en, commit, in_active, status_rd;
  logic [9:0]              col;
  logic                    unused_wd;

  assign rd_en     = bus.chipselect & bus.read;
  assign wr_en     = bus.chipselect & bus.write;
  assign status_rd = rd_en && (bus.address == A_STATUS);
  assign commit    = (hcount == 11'd0) && (vcount == 10'(COMMIT_LINE));
  assign col       = hcount[10:1];
  assign in_active = (col < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign unused_wd = ^bus.writedata[15:10];
  assign bus.readdata = readdata_q;

  // Register file. The commit copies the shadow value held before this
  // edge, so a coincident write only lands in shadow for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      frame_q <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= shadow_q[i];
        frame_q <= frame_q + 16'd1;
      end
      if (wr_en) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (bus.address == ADDR_BITS'(4 * i + int'(REG_X)))
            shadow_q[i].x <= bus.writedata[9:0];
          if (bus.address == ADDR_BITS'(4 * i + int'(REG_Y)))
            shadow_q[i].y <= bus.writedata[9:0];
          if (bus.address == ADDR_BITS'(4 * i + int'(REG_IMG)))
            shadow_q[i].img <= 4'(bus.writedata[IMG_BITS-1:0]);
          if (bus.address == ADDR_BITS'(4 * i + int'(REG_CTRL))) begin
            shadow_q[i].en    <= bus.writedata[CTRL_EN];
            shadow_q[i].hflip <= bus.writedata[CTRL_HFLIP];
            shadow_q[i].vflip <= bus.writedata[CTRL_VFLIP];
          end
        end
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (bus.address[ADDR_BITS-1:2] == (ADDR_BITS-2)'(i)) begin
          case (bus.address[1:0])
            REG_X:   readdata_d = 16'(shadow_q[i].x);
            REG_Y:   readdata_d = 16'(shadow_q[i].y);
            REG_IMG: readdata_d = 16'(shadow_q[i].img);
            default: readdata_d = 16'({shadow_q[i].vflip, shadow_q[i].hflip, shadow_q[i].en});
          endcase
        end
      end
      // Bit 0 of collision_q is never set, so STATUS bit 0 reads as 0.
      if (bus.address == A_STATUS) readdata_d = 16'(collision_q);
      if (bus.address == A_FRAME)  readdata_d = frame_q;
    end
  end

  // Stage 0: per-sprite hit test and ROM addressing from active registers.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
    logic [10:0]        dx, dy;
    logic [SZ_BITS-1:0] row, colm;
    logic [ROM_AW-1:0]  rom_addr;

    // 11-bit differences: bit 10 set means the raster is left of / above
    // the sprite, which also prevents wrap-around at the right edge.
    assign dx = {1'b0, col} - {1'b0, active_q[g].x};
    assign dy = {1'b0, vcount} - {1'b0, active_q[g].y};
    assign hit_s0[g] = active_q[g].en & in_active & ~dx[10] & ~dy[10]
                     & (dx < 11'(SPRITE_SIZE)) & (dy < 11'(SPRITE_SIZE));
    assign row  = active_q[g].vflip ? (SZ_BITS'(SPRITE_SIZE - 1) - dy[SZ_BITS-1:0]) : dy[SZ_BITS-1:0];
    assign colm = active_q[g].hflip ? (SZ_BITS'(SPRITE_SIZE - 1) - dx[SZ_BITS-1:0]) : dx[SZ_BITS-1:0];
    assign rom_addr = {active_q[g].img[IMG_BITS-1:0], row, colm};

    sprite_rom #(
      .SPRITE_SIZE (SPRITE_SIZE),
      .IMG_COUNT   (IMG_COUNT),
      .COLOR_BITS  (COLOR_BITS),
      .ROM_FILE    (ROM_FILE)
    ) u_rom (
      .clk    (clk),
      .addr_i (rom_addr),
      .q_o    (rom_q[g])
    );
  end

  // Stage 2 combinational: opacity, priority select, collision sets.
  always_comb begin
    win_valid = 1'b0;
    win_color = '0;
    win_idx   = '0;
    coll_set  = '0;
    for (int i = 0; i < NUM_SPRITES; i++) opaque[i] = hit_s1_q[i] & (rom_q[i] != '0);
    // Descending scan so the lowest opaque index is the last to write.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_valid = 1'b1;
        win_color = rom_q[i];
        win_idx   = 4'(i);
      end
    end
    for (int i = 1; i < NUM_SPRITES; i++) coll_set[i] = opaque[0] & opaque[i];
    // A new set outranks a same-cycle read-clear.
    collision_d = (status_rd ? '0 : collision_q) | coll_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_s1_q    <= '0;
      pix_valid   <= 1'b0;
      pix_color   <= '0;
      pix_sprite  <= '0;
      collision_q <= '0;
      readdata_q  <= '0;
    end else begin
      hit_s1_q    <= hit_s0;
      pix_valid   <= win_valid;
      pix_color   <= win_color;
      pix_sprite  <= win_idx;
      collision_q <= collision_d;
      readdata_q  <= readdata_d;
    end
  end

endmodule
`default_nettype wire
